// File: rtl/btn_pkg.sv
// Shared constants and types for the push-button conditioning front end.
package btn_pkg;

  localparam int N_BTN_DEFAULT = 5;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } db_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button: 2-flop synchroniser, debounce FSM with stability counter, and
// registered level/press/release. Auto-repeat is built only with BTN_REPEAT_EN.
module debounce_cell
  import btn_pkg::*;
#(
  parameter int DB_CYCLES = 500000
`ifdef BTN_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
`endif
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      btn_raw_i,
  output logic      level_o,
  output logic      press_o,
  output logic      release_o,
  output db_state_t state_o
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          btn_sync;
  db_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  assign btn_sync = sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      state_q   <= STABLE_LO;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_raw_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      STABLE_LO: if (btn_sync) state_d = CHK_HI;
      CHK_HI: begin
        if (!btn_sync)              state_d = STABLE_LO;
        else if (cnt_q == CNT_LAST) state_d = STABLE_HI;
      end
      STABLE_HI: if (!btn_sync) state_d = CHK_LO;
      CHK_LO: begin
        if (btn_sync)               state_d = STABLE_HI;
        else if (cnt_q == CNT_LAST) state_d = STABLE_LO;
      end
      default: state_d = STABLE_LO;
    endcase
  end

`ifdef BTN_REPEAT_EN
  localparam int RW = $clog2(max2(REPEAT_DELAY, REPEAT_RATE) + 1);

  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_armed_q, rpt_armed_d;
  logic [RW-1:0] rpt_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_armed_q <= rpt_armed_q ? rpt_armed_d : rpt_armed_d;
    end
  end

  // First repeat waits REPEAT_DELAY; once armed, each further one waits REPEAT_RATE.
  assign rpt_last = rpt_armed_q ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1);
`endif

  always_comb begin
    cnt_d     = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      STABLE_LO, STABLE_HI: cnt_d = (state_d != state_q) ? CW'(1) : '0;
      default:              cnt_d = (state_d == state_q) ? cnt_q + CW'(1) : '0;
    endcase
    if (state_q == CHK_HI && state_d == STABLE_HI) begin
      level_d = 1'b1;
      press_d = 1'b1;
    end
    if (state_q == CHK_LO && state_d == STABLE_LO) begin
      level_d   = 1'b0;
      release_d = 1'b1;
    end
`ifdef BTN_REPEAT_EN
    rpt_cnt_d   = '0;
    rpt_armed_d = 1'b0;
    if (state_q == STABLE_HI && state_d == STABLE_HI) begin
      if (rpt_cnt_q == rpt_last) begin
        press_d     = 1'b1;
        rpt_armed_d = 1'b1;
      end else begin
        rpt_cnt_d   = rpt_cnt_q + RW'(1);
        rpt_armed_d = rpt_armed_q;
      end
    end
`endif
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign state_o   = state_q;

endmodule

// File: rtl/btn_conditioner.sv
// Button front end for led_cycle: one debounce_cell per button plus the sticky
// one-hot speed selection. Define BTN_REPEAT_EN to build hold-to-repeat presses.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN        = N_BTN_DEFAULT,
  parameter int DB_CYCLES    = 500000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] sel
);

  if (DB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("btn_conditioner: illegal parameter values");
  end

  // Per-button FSM state, kept as a named signal for debug probing.
  db_state_t [N_BTN-1:0] dbg_state_unused;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_cell
    debounce_cell #(
      .DB_CYCLES   (DB_CYCLES)
`ifdef BTN_REPEAT_EN
      ,
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
`endif
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .btn_raw_i(btn_raw[gi]),
      .level_o  (btn_level[gi]),
      .press_o  (btn_press[gi]),
      .release_o(btn_release[gi]),
      .state_o  (dbg_state_unused[gi])
    );
  end

  logic [N_BTN-1:0] sel_q, sel_d;

  // Later loop iterations override earlier ones, so the highest pressed index wins.
  always_comb begin
    sel_d = sel_q;
    for (int i = 0; i < N_BTN; i++) begin
      if (btn_press[i]) begin
        sel_d    = '0;
        sel_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sel_q <= '0;
    else       sel_q <= sel_d;
  end

  assign sel = sel_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_btn_conditioner;
  import btn_pkg::*;

  localparam int NB = 5;

  logic          clk;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic [NB-1:0] sel;

  int n_checks = 0;
  int n_pass   = 0;

  btn_conditioner #(
    .N_BTN       (NB),
    .DB_CYCLES   (4),
    .REPEAT_DELAY(10),
    .REPEAT_RATE (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .sel        (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    btn_raw = '0;
    step(5);
    n_checks++;
    if (btn_level !== 5'b00000) $display("FAIL reset_level: got %b want 00000", btn_level); else n_pass++;
    n_checks++;
    if (btn_press !== 5'b00000) $display("FAIL reset_press: got %b want 00000", btn_press); else n_pass++;
    n_checks++;
    if (btn_release !== 5'b00000) $display("FAIL reset_release: got %b want 00000", btn_release); else n_pass++;
    n_checks++;
    if (sel !== 5'b00000) $display("FAIL reset_sel: got %b want 00000", sel); else n_pass++;
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      n_checks++;
      if ({btn_level, btn_press, btn_release, sel} !== 20'h0)
        $display("FAIL idle_cycle%0d: lvl=%b prs=%b rel=%b sel=%b want all 0",
                 c, btn_level, btn_press, btn_release, sel);
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    btn_raw[BTN_L] = 1'b1;
    step(5);
    n_checks++;
    if (btn_press !== 5'b00000 || btn_level !== 5'b00000)
      $display("FAIL press_early: prs=%b lvl=%b want 00000/00000", btn_press, btn_level);
    else n_pass++;
    step(1);
    n_checks++;
    if (btn_press !== 5'b00100) $display("FAIL press_pulse: got %b want 00100", btn_press); else n_pass++;
    n_checks++;
    if (btn_level !== 5'b00100) $display("FAIL press_level: got %b want 00100", btn_level); else n_pass++;
    step(1);
    n_checks++;
    if (btn_press !== 5'b00000) $display("FAIL press_one_cycle: got %b want 00000", btn_press); else n_pass++;
    n_checks++;
    if (sel !== 5'b00100) $display("FAIL press_sel: got %b want 00100", sel); else n_pass++;
    step(3);
    btn_raw[BTN_L] = 1'b0;
    step(5);
    n_checks++;
    if (btn_release !== 5'b00000 || btn_level !== 5'b00100)
      $display("FAIL release_early: rel=%b lvl=%b want 00000/00100", btn_release, btn_level);
    else n_pass++;
    step(1);
    n_checks++;
    if (btn_release !== 5'b00100 || btn_level !== 5'b00000)
      $display("FAIL release_pulse: rel=%b lvl=%b want 00100/00000", btn_release, btn_level);
    else n_pass++;
    step(1);
    n_checks++;
    if (btn_release !== 5'b00000) $display("FAIL release_one_cycle: got %b want 00000", btn_release); else n_pass++;
    n_checks++;
    if (sel !== 5'b00100) $display("FAIL release_sel_hold: got %b want 00100", sel); else n_pass++;
  endtask

  task automatic test_bounce();
    for (int r = 0; r < 3; r++) begin
      btn_raw[BTN_C] = 1'b1;
      for (int c = 0; c < 5; c++) begin
        step(1);
        if (c == 1) btn_raw[BTN_C] = 1'b0;
        n_checks++;
        if (btn_press !== 5'b00000 || btn_level[BTN_C] !== 1'b0)
          $display("FAIL bounce_r%0d_c%0d: prs=%b lvl=%b want no press, level0 low",
                   r, c, btn_press, btn_level);
        else n_pass++;
      end
    end
    step(6);
    n_checks++;
    if (btn_level !== 5'b00000) $display("FAIL bounce_level: got %b want 00000", btn_level); else n_pass++;
    n_checks++;
    if (sel !== 5'b00100) $display("FAIL bounce_sel: got %b want 00100", sel); else n_pass++;
  endtask

  task automatic test_simultaneous();
    btn_raw = 5'b10010;
    step(5);
    n_checks++;
    if (btn_press !== 5'b00000) $display("FAIL simul_early: got %b want 00000", btn_press); else n_pass++;
    step(1);
    n_checks++;
    if (btn_press !== 5'b10010) $display("FAIL simul_press: got %b want 10010", btn_press); else n_pass++;
    step(1);
    n_checks++;
    if (sel !== 5'b10000) $display("FAIL simul_sel: got %b want 10000", sel); else n_pass++;
    n_checks++;
    if (btn_level !== 5'b10010) $display("FAIL simul_level: got %b want 10010", btn_level); else n_pass++;
    btn_raw = '0;
    step(8);
    n_checks++;
    if (btn_level !== 5'b00000 || sel !== 5'b10000)
      $display("FAIL simul_after_release: lvl=%b sel=%b want 00000/10000", btn_level, sel);
    else n_pass++;
  endtask

  task automatic test_reset_mid_check();
    btn_raw[BTN_R] = 1'b1;
    step(2);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(1);
      n_checks++;
      if (btn_press !== 5'b00000 || btn_level !== 5'b00000 || sel !== 5'b00000)
        $display("FAIL midrst_hold%0d: prs=%b lvl=%b sel=%b want all 0", c, btn_press, btn_level, sel);
      else n_pass++;
    end
    reset = 1'b0;
    step(5);
    n_checks++;
    if (btn_press !== 5'b00000) $display("FAIL midrst_early: got %b want 00000", btn_press); else n_pass++;
    step(1);
    n_checks++;
    if (btn_press !== 5'b01000) $display("FAIL midrst_press: got %b want 01000", btn_press); else n_pass++;
    step(1);
    n_checks++;
    if (sel !== 5'b01000) $display("FAIL midrst_sel: got %b want 01000", sel); else n_pass++;
    btn_raw = '0;
    step(8);
  endtask

  task automatic test_repeat();
    logic exp_p;
    logic exp_r;
    btn_raw[BTN_U] = 1'b1;
    for (int m = 1; m <= 40; m++) begin
      step(1);
`ifdef BTN_REPEAT_EN
      exp_p = (m == 6) || (m >= 16 && m <= 31 && ((m - 16) % 3) == 0);
`else
      exp_p = (m == 6);
`endif
      exp_r = (m == 36);
      n_checks++;
      if (btn_press[BTN_U] !== exp_p || btn_release[BTN_U] !== exp_r)
        $display("FAIL repeat_m%0d: press1=%b rel1=%b want %b/%b",
                 m, btn_press[BTN_U], btn_release[BTN_U], exp_p, exp_r);
      else n_pass++;
      if (m == 30) btn_raw[BTN_U] = 1'b0;
    end
    n_checks++;
    if (sel !== 5'b00010) $display("FAIL repeat_sel: got %b want 00010", sel); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid_check();
    test_repeat();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
